muldiv_unit: RTL

Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the pipelined core's EX stage. It replaces single-cycle combinational M handling with a multi-cycle shift-add/restoring-divide datapath. It reports `busy` so the hazard logic can stall IF/ID/EX, and pulses `done` with the result for EX_MEM capture. The unit is generalised over operand width and supports pipeline flush mid-operation.

---
 rtl/muldiv_unit_pkg.sv | 32 +++
 rtl/muldiv_datapath.sv | 74 +++++++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit.
//   - RV32M funct3 encodings for the eight M-extension operations.
//   - FSM state encoding (2 bits).
//   - Helpers deciding which operands an operation treats as signed.
package muldiv_unit_pkg;

    localparam logic [2:0] F3Mul    = 3'b000;
    localparam logic [2:0] F3Mulh   = 3'b001;
    localparam logic [2:0] F3Mulhsu = 3'b010;
    localparam logic [2:0] F3Mulhu  = 3'b011;
    localparam logic [2:0] F3Div    = 3'b100;
    localparam logic [2:0] F3Divu   = 3'b101;
    localparam logic [2:0] F3Rem    = 3'b110;
    localparam logic [2:0] F3Remu   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } state_e;

    // MUL is computed unsigned: its low half is sign-agnostic.
    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == F3Mulh) || (f == F3Mulhsu) || (f == F3Div) || (f == F3Rem);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == F3Mulh) || (f == F3Div) || (f == F3Rem);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath on unsigned magnitudes.
// Ports:
//   clk, rst      clock, synchronous active-low reset (clears all state)
//   init          load operands: mul -> acc = {0, b}, div -> acc = {0, a}
//   step          perform one multiply or divide iteration
//   is_div        selects divide behaviour for init/step and for negation
//   negate        combinational two's-complement of the outputs
//   a_mag, b_mag  operand magnitudes
//   res_hi        mul: product high half; div: remainder
//   res_lo        mul: product low half;  div: quotient
module muldiv_datapath #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         step,
    input  logic         is_div,
    input  logic         negate,
    input  logic [N-1:0] a_mag,
    input  logic [N-1:0] b_mag,
    output logic [N-1:0] res_hi,
    output logic [N-1:0] res_lo
);

    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   opnd_q, opnd_d;   // multiplicand or divisor

    logic [N-1:0]   hi, lo;
    logic [N:0]     add_sum;
    logic [N:0]     part_rem;
    logic [N:0]     diff;
    logic [2*N-1:0] mul_next, div_next, neg_full;
    logic [N-1:0]   neg_hi;

    always_comb begin
        hi       = acc_q[2*N-1:N];
        lo       = acc_q[N-1:0];
        // Multiply: conditionally add multiplicand into the high half, shift right with carry.
        add_sum  = {1'b0, hi} + {1'b0, opnd_q};
        mul_next = lo[0] ? {add_sum, lo[N-1:1]} : {1'b0, hi, lo[N-1:1]};
        // Divide: shift next dividend bit into the remainder, keep the difference if non-negative.
        part_rem = {hi, lo[N-1]};
        diff     = part_rem - {1'b0, opnd_q};
        div_next = diff[N] ? {part_rem[N-1:0], lo[N-2:0], 1'b0}
                           : {diff[N-1:0], lo[N-2:0], 1'b1};

        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (init) begin
            acc_d  = {{N{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd_d = is_div ? b_mag : a_mag;
        end else if (step) begin
            acc_d = is_div ? div_next : mul_next;
        end

        // A product is negated as one 2N-bit value; quotient and remainder independently.
        neg_full = -acc_q;
        neg_hi   = -hi;
        res_lo   = negate ? neg_full[N-1:0] : lo;
        res_hi   = negate ? (is_div ? neg_hi : neg_full[2*N-1:N]) : hi;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit (latency N+2, special divides 1).
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   start, flush   request (accepted in IDLE/DONE), abort to IDLE (beats start)
//   funct3         M-extension operation select
//   op_a, op_b     rs1 / rs2 operands
//   busy           high in CALC and FIX (pipeline stall)
//   done           one-cycle pulse, result valid
//   result         last completed result, held until the next completion
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned FUNCT3 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic [FUNCT3-1:0] funct3,
    input  logic [N-1:0]      op_a,
    input  logic [N-1:0]      op_b,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      result
);

    localparam int unsigned    CntW    = $clog2(N) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
    localparam logic [N-1:0]   MinNeg  = {1'b1, {(N - 1){1'b0}}};

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [FUNCT3-1:0]   funct3_q, funct3_d;
    logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [N-1:0]        result_q, result_d;

    logic                in_sign_a, in_sign_b, div_zero, div_ovf;
    logic [N-1:0]        a_mag, b_mag, res_hi, res_lo;
    logic                dp_init, dp_step, dp_is_div, dp_negate;

    always_comb begin
        in_sign_a = op_a_signed(funct3) & op_a[N-1];
        in_sign_b = op_b_signed(funct3) & op_b[N-1];
        a_mag     = in_sign_a ? -op_a : op_a;
        b_mag     = in_sign_b ? -op_b : op_b;
        div_zero  = funct3[2] && (op_b == '0);
        div_ovf   = ((funct3 == F3Div) || (funct3 == F3Rem)) && (op_a == MinNeg) && (&op_b);

        // Quotient and product take sign(a)^sign(b); remainder follows the dividend.
        case (funct3_q)
            F3Mulh, F3Mulhsu, F3Div: dp_negate = sign_a_q ^ sign_b_q;
            F3Rem:                   dp_negate = sign_a_q;
            default:                 dp_negate = 1'b0;
        endcase

        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        result_d  = result_q;
        dp_init   = 1'b0;
        dp_step   = 1'b0;
        dp_is_div = funct3_q[2];

        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        funct3_d  = funct3;
                        sign_a_d  = in_sign_a;
                        sign_b_d  = in_sign_b;
                        cnt_d     = '0;
                        dp_init   = 1'b1;
                        dp_is_div = funct3[2];
                        if (div_zero) begin
                            state_d  = StDone;
                            done_d   = 1'b1;
                            result_d = funct3[1] ? op_a : '1;
                        end else if (div_ovf) begin
                            state_d  = StDone;
                            done_d   = 1'b1;
                            result_d = funct3[1] ? '0 : op_a;
                        end else begin
                            state_d = StCalc;
                            busy_d  = 1'b1;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StCalc: begin
                    dp_step = 1'b1;
                    cnt_d   = cnt_q + CntW'(1);
                    busy_d  = 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    if (funct3_q == F3Mul) begin
                        result_d = res_lo;
                    end else if (!funct3_q[2]) begin
                        result_d = res_hi;
                    end else begin
                        result_d = funct3_q[1] ? res_hi : res_lo;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            funct3_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    muldiv_datapath #(
        .N (N)
    ) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .init   (dp_init),
        .step   (dp_step),
        .is_div (dp_is_div),
        .negate (dp_negate),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
